// File: rtl/grid_match_core.sv
// grid_match_core: cell-select matching game with a scanned LED-matrix display.
// A target map is written row by row while idle; the player flips (or sets) cells
// while playing, and each accepted select triggers a row-by-row compare pass.
//
// Ports:
//   clock, reset (async, active-low)
//   enable                        game running (level)
//   load, load_row, load_data     write one target row (IDLE only)
//   sel_valid, sel_row, sel_col   player cell select (PLAY only)
//   clear                         zero player grid, move count and finish
//   row, col                      one-hot scan row and its pixel data
//   moves                         accepted-select count (saturating)
//   finish                        player grid matched the target map
//   busy                          compare pass in progress
module grid_match_core #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned MODE     = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     load,
    input  logic [$clog2(ROWS)-1:0]  load_row,
    input  logic [COLS-1:0]          load_data,
    input  logic                     sel_valid,
    input  logic [$clog2(ROWS)-1:0]  sel_row,
    input  logic [$clog2(COLS)-1:0]  sel_col,
    input  logic                     clear,
    output logic [ROWS-1:0]          row,
    output logic [COLS-1:0]          col,
    output logic [CNT_W-1:0]         moves,
    output logic                     finish,
    output logic                     busy
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [COLS-1:0]   target [ROWS];
    logic [COLS-1:0]   player [ROWS];
    logic [RW-1:0]     chk_idx;
    logic [DW-1:0]     div;
    logic [DW-1:0]     div_nxt;
    logic [RW-1:0]     scan;
    logic [RW-1:0]     scan_nxt;
    logic              sel_ok;
    logic              row_match;
    logic              chk_last;

    // Next-state and select qualification
    always_comb begin
        state_nxt = state;
        sel_ok    = 1'b0;
        row_match = (player[chk_idx] == target[chk_idx]);
        chk_last  = (32'(chk_idx) == ROWS - 1);

        // clear wins over a same-edge select
        sel_ok = enable && !clear && sel_valid && (state == PLAY) &&
                 (32'(sel_row) < ROWS) && (32'(sel_col) < COLS);

        if (!enable) begin
            state_nxt = IDLE;
        end else if (clear) begin
            state_nxt = (state == IDLE) ? IDLE : PLAY;
        end else begin
            case (state)
                IDLE:    state_nxt = PLAY;
                PLAY:    if (sel_ok) state_nxt = CHECK;
                CHECK: begin
                    if (!row_match)    state_nxt = PLAY;
                    else if (chk_last) state_nxt = DONE;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Scan divider and row index, free-running regardless of game state
    always_comb begin
        div_nxt  = div + DW'(1);
        scan_nxt = scan;
        if (32'(div) == SCAN_DIV - 1) begin
            div_nxt  = '0;
            scan_nxt = (32'(scan) == ROWS - 1) ? '0 : scan + RW'(1);
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grids, move counter, compare progress and status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            target  <= '{default: '0};
            player  <= '{default: '0};
            moves   <= '0;
            finish  <= 1'b0;
            busy    <= 1'b0;
            chk_idx <= '0;
        end else begin
            if (state == IDLE && load && (32'(load_row) < ROWS))
                target[load_row] <= load_data;

            if (clear) begin
                player <= '{default: '0};
                moves  <= '0;
            end else if (sel_ok) begin
                player[sel_row][sel_col] <= (MODE == 1) ? 1'b1 : ~player[sel_row][sel_col];
                if (moves != {CNT_W{1'b1}})
                    moves <= moves + CNT_W'(1);
            end

            if (clear)
                finish <= 1'b0;
            else if (state == CHECK && state_nxt == DONE)
                finish <= 1'b1;

            busy    <= (state_nxt == CHECK);
            chk_idx <= (state == CHECK && state_nxt == CHECK) ? chk_idx + RW'(1) : '0;
        end
    end

    // Display drive: row and its pixels registered together so they stay aligned
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div  <= '0;
            scan <= '0;
            row  <= ROWS'(1);
            col  <= '0;
        end else begin
            div  <= div_nxt;
            scan <= scan_nxt;
            row  <= ROWS'(1) << scan_nxt;
            col  <= (state_nxt == IDLE) ? target[scan_nxt] : player[scan_nxt];
        end
    end

endmodule

// File: tb/tb_grid_match_core.sv
// Self-checking bench for grid_match_core: a toggle-mode 8x16 instance driven from
// a cycle table, plus a set-mode 6-row instance with a 2-bit move counter.
module tb_grid_match_core;

    logic clock;

    // Instance 0: ROWS=8, COLS=16, CNT_W=8, MODE=0, SCAN_DIV=4
    logic        reset0, enable0, load0, sel_valid0, clear0;
    logic [2:0]  load_row0, sel_row0;
    logic [15:0] load_data0;
    logic [3:0]  sel_col0;
    logic [7:0]  row0;
    logic [15:0] col0;
    logic [7:0]  moves0;
    logic        finish0, busy0;

    // Instance 1: ROWS=6, COLS=16, CNT_W=2, MODE=1, SCAN_DIV=4
    logic        reset1, enable1, load1, sel_valid1, clear1;
    logic [2:0]  load_row1, sel_row1;
    logic [15:0] load_data1;
    logic [3:0]  sel_col1;
    logic [5:0]  row1;
    logic [15:0] col1;
    logic [1:0]  moves1;
    logic        finish1, busy1;

    grid_match_core #(.ROWS(8), .COLS(16), .CNT_W(8), .SCAN_DIV(4), .MODE(0)) u0 (
        .clock(clock), .reset(reset0), .enable(enable0), .load(load0),
        .load_row(load_row0), .load_data(load_data0), .sel_valid(sel_valid0),
        .sel_row(sel_row0), .sel_col(sel_col0), .clear(clear0),
        .row(row0), .col(col0), .moves(moves0), .finish(finish0), .busy(busy0));

    grid_match_core #(.ROWS(6), .COLS(16), .CNT_W(2), .SCAN_DIV(4), .MODE(1)) u1 (
        .clock(clock), .reset(reset1), .enable(enable1), .load(load1),
        .load_row(load_row1), .load_data(load_data1), .sel_valid(sel_valid1),
        .sel_row(sel_row1), .sel_col(sel_col1), .clear(clear1),
        .row(row1), .col(col1), .moves(moves1), .finish(finish1), .busy(busy1));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        en;
        logic        ld;
        logic [2:0]  lr;
        logic [15:0] ldd;
        logic        sv;
        logic [2:0]  sr;
        logic [3:0]  sc;
        logic        clr;
        logic [7:0]  e_moves;
        logic        e_fin;
        logic        e_busy;
    } vec_t;

    vec_t        tbl[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] fr [8];
    logic [7:0]  seen;

    function automatic vec_t mk(input logic en, input logic ld, input logic [2:0] lr,
                                input logic [15:0] ldd, input logic sv, input logic [2:0] sr,
                                input logic [3:0] sc, input logic clr, input logic [7:0] m,
                                input logic f, input logic b);
        vec_t v;
        v.en = en; v.ld = ld; v.lr = lr; v.ldd = ldd; v.sv = sv; v.sr = sr; v.sc = sc;
        v.clr = clr; v.e_moves = m; v.e_fin = f; v.e_busy = b;
        return v;
    endfunction

    function automatic vec_t idle(input logic [7:0] m, input logic f, input logic b);
        return mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 4'd0, 1'b0, m, f, b);
    endfunction

    function automatic vec_t sel(input logic [2:0] r, input logic [3:0] c,
                                 input logic [7:0] m, input logic f, input logic b);
        return mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, r, c, 1'b0, m, f, b);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Capture one full display frame from the chosen instance into fr[]
    task automatic read_frame(input int inst);
        logic [7:0]  r;
        logic [15:0] c;
        int          nrows;
        nrows = (inst == 0) ? 8 : 6;
        seen  = '0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            r = (inst == 0) ? row0 : {2'b00, row1};
            c = (inst == 0) ? col0 : col1;
            for (int i = 0; i < 8; i++)
                if (r == (8'd1 << i)) begin
                    fr[i]   = c;
                    seen[i] = 1'b1;
                end
            if ($countones(seen) == nrows) break;
        end
        chk($sformatf("frame%0d_complete", inst), 32'($countones(seen)), 32'(nrows));
    endtask

    task automatic sel1(input logic [2:0] r, input logic [3:0] c, input logic [1:0] exp_m,
                        input string nm);
        @(negedge clock);
        sel_valid1 = 1'b1; sel_row1 = r; sel_col1 = c;
        @(posedge clock); #1;
        chk(nm, 32'(moves1), 32'(exp_m));
        @(negedge clock);
        sel_valid1 = 1'b0;
    endtask

    task automatic wait_idle1(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (!busy1) break;
            @(negedge clock);
        end
        chk(nm, 32'(busy1), 32'd0);
    endtask

    initial begin
        reset0 = 1'b1; enable0 = 1'b0; load0 = 1'b0; load_row0 = '0; load_data0 = '0;
        sel_valid0 = 1'b0; sel_row0 = '0; sel_col0 = '0; clear0 = 1'b0;
        reset1 = 1'b1; enable1 = 1'b0; load1 = 1'b0; load_row1 = '0; load_data1 = '0;
        sel_valid1 = 1'b0; sel_row1 = '0; sel_col1 = '0; clear1 = 1'b0;

        // Reset values
        #2;
        reset0 = 1'b0; reset1 = 1'b0;
        #1;
        chk("rst_moves0", 32'(moves0), 32'd0);
        chk("rst_finish0", 32'(finish0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_row0", 32'(row0), 32'h01);
        chk("rst_col0", 32'(col0), 32'h0);
        chk("rst_row1", 32'(row1), 32'h01);
        chk("rst_moves1", 32'(moves1), 32'd0);

        // Scan: row advances every 4 edges after reset release, wraps 0x80 -> 0x01
        @(negedge clock);
        @(negedge clock);
        reset0 = 1'b1; reset1 = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clock); #1;
            chk($sformatf("scan_k%0d", k), 32'(row0), 32'(8'd1 << ((k / 4) % 8)));
        end

        // Cycle table for instance 0
        tbl.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0001, 1'b0, 3'd0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(sel(3'd0, 4'd0, 8'd1, 1'b0, 1'b1));
        tbl.push_back(idle(8'd1, 1'b0, 1'b1));
        tbl.push_back(sel(3'd1, 4'd3, 8'd1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b0, 3'd0, 4'd0, 1'b0, 8'd1, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++) tbl.push_back(idle(8'd1, 1'b0, 1'b1));
        tbl.push_back(idle(8'd1, 1'b1, 1'b0));
        tbl.push_back(sel(3'd0, 4'd0, 8'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 4'd0, 1'b1, 8'd0, 1'b0, 1'b0));
        tbl.push_back(sel(3'd0, 4'd0, 8'd1, 1'b0, 1'b1));
        for (int i = 0; i < 7; i++) tbl.push_back(idle(8'd1, 1'b0, 1'b1));
        tbl.push_back(idle(8'd1, 1'b1, 1'b0));
        tbl.push_back(sel(3'd0, 4'd0, 8'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 4'd0, 1'b0, 8'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 4'd0, 1'b1, 8'd0, 1'b0, 1'b0));
        tbl.push_back(idle(8'd0, 1'b0, 1'b0));
        tbl.push_back(sel(3'd1, 4'd2, 8'd1, 1'b0, 1'b1));
        tbl.push_back(idle(8'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 4'd0, 1'b1, 8'd0, 1'b0, 1'b0));
        tbl.push_back(idle(8'd0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            @(negedge clock);
            enable0 = tbl[i].en; load0 = tbl[i].ld; load_row0 = tbl[i].lr;
            load_data0 = tbl[i].ldd; sel_valid0 = tbl[i].sv; sel_row0 = tbl[i].sr;
            sel_col0 = tbl[i].sc; clear0 = tbl[i].clr;
            @(posedge clock); #1;
            chk($sformatf("v%0d_moves", i), 32'(moves0), 32'(tbl[i].e_moves));
            chk($sformatf("v%0d_finish", i), 32'(finish0), 32'(tbl[i].e_fin));
            chk($sformatf("v%0d_busy", i), 32'(busy0), 32'(tbl[i].e_busy));
        end
        @(negedge clock);
        load0 = 1'b0; sel_valid0 = 1'b0; clear0 = 1'b0;

        // Player grid is empty after clear beat the simultaneous select
        @(negedge clock);
        read_frame(0);
        for (int i = 0; i < 8; i++) chk($sformatf("play_frame_r%0d", i), 32'(fr[i]), 32'h0);

        // IDLE shows the target map; the load issued during CHECK never landed
        enable0 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        read_frame(0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tgt_frame_r%0d", i), 32'(fr[i]), (i == 0) ? 32'h0001 : 32'h0);

        // Reset in the 3rd CHECK cycle
        enable0 = 1'b1;
        @(negedge clock);
        sel_valid0 = 1'b1; sel_row0 = 3'd0; sel_col0 = 4'd0;
        @(negedge clock);
        sel_valid0 = 1'b0;
        chk("midchk_busy_before", 32'(busy0), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset0 = 1'b0;
        #1;
        chk("midchk_moves", 32'(moves0), 32'd0);
        chk("midchk_finish", 32'(finish0), 32'd0);
        chk("midchk_busy", 32'(busy0), 32'd0);
        chk("midchk_row", 32'(row0), 32'h01);
        chk("midchk_col", 32'(col0), 32'h0);
        enable0 = 1'b0;
        @(negedge clock);
        reset0 = 1'b1;
        read_frame(0);
        for (int i = 0; i < 8; i++) chk($sformatf("post_rst_tgt_r%0d", i), 32'(fr[i]), 32'h0);

        // Instance 1: set mode, drops and 2-bit saturation
        enable1 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        sel1(3'd2, 4'd5, 2'd1, "m1_sel1");
        wait_idle1("m1_idle1");
        sel1(3'd2, 4'd5, 2'd2, "m1_sel2");
        wait_idle1("m1_idle2");
        read_frame(1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("m1_frame_r%0d", i), 32'(fr[i]), (i == 2) ? 32'h0020 : 32'h0);
        sel1(3'd6, 4'd0, 2'd2, "m1_oor_row");
        chk("m1_oor_busy", 32'(busy1), 32'd0);
        sel1(3'd0, 4'd0, 2'd3, "m1_sat3");
        wait_idle1("m1_idle3");
        sel1(3'd0, 4'd1, 2'd3, "m1_sat4");
        wait_idle1("m1_idle4");
        sel1(3'd0, 4'd2, 2'd3, "m1_sat5");
        wait_idle1("m1_idle5");
        read_frame(1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("m1_frame2_r%0d", i), 32'(fr[i]),
                (i == 0) ? 32'h0007 : ((i == 2) ? 32'h0020 : 32'h0));
        chk("m1_finish", 32'(finish1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
